// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default latencies for the pipeline stall/flush sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // mul/div sequencing states
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  localparam int DEF_MULT_LAT = 2;
  localparam int DEF_DIV_LAT  = 33;
  localparam int DEF_CNT_W    = 6;

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// Mul/div cycle counter: load, decrement, clear, with a zero flag.
// Latency: count updates on the clock edge; zero is combinational from the count.
// Backpressure: the caller withholds dec during stalls to freeze the count.
module md_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // clear wins over load, load wins over decrement
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 7-stage pipeline; optional PIPE_CTRL_PERF_EN adds stall/redirect counters.
// Latency: all enables/flushes/redirect are combinational, acting on the next clock edge.
// Backpressure: dcache stall freezes everything; mul/div, load-use and icache stall hold upstream and bubble downstream.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_stall,
  input  logic        dcache_stall,
  input  logic        load_use,
  input  logic        md_start,
  input  logic        md_op,
  input  logic        mem2_exception,
  input  logic        mem2_eret,
  output logic        pc_wr,
  output logic        pf_if_wr,
  output logic        if_id_wr,
  output logic        id_ex_wr,
  output logic        ex_mem1_wr,
  output logic        mem1_mem2_wr,
  output logic        mem2_wb_wr,
  output logic        pf_flush,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem1_flush,
  output logic        mem2_flush,
  output logic        redirect,
  output logic        md_busy,
  output logic        md_done
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

  state_t           state, state_nxt;
  logic             t_clr, t_load, t_dec;
  logic             t_zero;
  logic [CNT_W-1:0] t_cnt;
  logic             ev, md_stall;

  md_timer #(.CNT_W(CNT_W)) u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (t_clr),
    .load     (t_load),
    .load_val (md_op ? DIV_LD : MULT_LD),
    .dec      (t_dec),
    .cnt      (t_cnt),
    .zero     (t_zero)
  );

  assign ev       = (mem2_exception | mem2_eret) & ~dcache_stall;
  assign md_stall = ((state == RUN) & md_start) | (state == MD_BUSY);

  // state register; reset always lands in RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // priority resolution of enables/flushes plus mul/div next-state
  always_comb begin
    pc_wr        = 1'b0;
    pf_if_wr     = 1'b0;
    if_id_wr     = 1'b0;
    id_ex_wr     = 1'b0;
    ex_mem1_wr   = 1'b0;
    mem1_mem2_wr = 1'b0;
    mem2_wb_wr   = 1'b0;
    pf_flush     = 1'b0;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    ex_flush     = 1'b0;
    mem1_flush   = 1'b0;
    mem2_flush   = 1'b0;
    redirect     = 1'b0;
    state_nxt    = state;
    t_clr        = 1'b0;
    t_load       = 1'b0;
    t_dec        = 1'b0;
    if (!rst) begin
      // everything held quiet while in reset
    end else if (ev) begin
      {pc_wr, pf_if_wr, if_id_wr, id_ex_wr, ex_mem1_wr, mem1_mem2_wr, mem2_wb_wr} = '1;
      {pf_flush, if_flush, id_flush, ex_flush, mem1_flush, mem2_flush} = '1;
      redirect  = 1'b1;
      t_clr     = 1'b1;
      state_nxt = RUN;
    end else if (dcache_stall) begin
      // full freeze; a pending MEM2 event waits for the data access
    end else begin
      if (md_stall) begin
        ex_flush     = 1'b1;
        mem1_mem2_wr = 1'b1;
        mem2_wb_wr   = 1'b1;
      end else if (load_use) begin
        id_flush     = 1'b1;
        id_ex_wr     = 1'b1;
        ex_mem1_wr   = 1'b1;
        mem1_mem2_wr = 1'b1;
        mem2_wb_wr   = 1'b1;
      end else if (icache_stall) begin
        if_flush     = 1'b1;
        if_id_wr     = 1'b1;
        id_ex_wr     = 1'b1;
        ex_mem1_wr   = 1'b1;
        mem1_mem2_wr = 1'b1;
        mem2_wb_wr   = 1'b1;
      end else begin
        {pc_wr, pf_if_wr, if_id_wr, id_ex_wr, ex_mem1_wr, mem1_mem2_wr, mem2_wb_wr} = '1;
      end
      unique case (state)
        RUN: begin
          if (md_start) begin
            t_load    = 1'b1;
            state_nxt = MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (t_zero) begin
            state_nxt = MD_DONE;
          end else begin
            t_dec = 1'b1;
          end
        end
        MD_DONE: begin
          if (ex_mem1_wr) begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign md_busy = rst & (state == MD_BUSY);
  assign md_done = rst & (state == MD_DONE);

`ifdef PIPE_CTRL_PERF_EN
  // count cycles with the PC held and cycles with a redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!pc_wr) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
